// File: rtl/cpu_pkg.sv
// Shared definitions for the decode-stage hazard controller.
// Forward selects, hazard FSM states and the register-match helper.
package cpu_pkg;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_ALUE = 2'b01;
  localparam logic [1:0] FWD_DMEM = 2'b10;
  localparam logic [1:0] FWD_WB   = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    MDUW = 2'd2
  } hz_state_t;

  // r0 is hardwired, so it never matches a writer
  function automatic logic reg_match(
    input logic [4:0] src,
    input logic [4:0] wa,
    input logic       we
  );
    return we && (wa != REG_ZERO) && (src == wa);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Per-operand forward select for the decode stage.
// Youngest producer wins; a load still in EX cannot forward.
module fwd_sel
  import cpu_pkg::*;
(
  input  logic [4:0] src,
  input  logic       en,
  input  logic [4:0] ex_wa,
  input  logic       ex_we,
  input  logic       ex_is_load,
  input  logic [4:0] mem_wa,
  input  logic       mem_we,
  input  logic [4:0] wb_wa,
  input  logic       wb_we,
  output logic [1:0] sel
);

  // priority EX > MEM > WB, loads in EX fall back to regfile
  always_comb begin
    sel = FWD_RF;
    if (!en) begin
      sel = FWD_RF;
    end else if (reg_match(src, ex_wa, ex_we)) begin
      sel = ex_is_load ? FWD_RF : FWD_ALUE;
    end else if (reg_match(src, mem_wa, mem_we)) begin
      sel = FWD_DMEM;
    end else if (reg_match(src, wb_wa, wb_we)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: forwarding, load-use and
// MDU-busy stalls, MDU busy sequencing and a stall-cycle counter.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned MDU_LAT = 32,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_id_valid,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_id_useRs,
  input  logic             i_id_useRt,
  input  logic             i_id_isMdu,
  input  logic             i_id_readsHiLo,
  input  logic [4:0]       i_ex_wa,
  input  logic             i_ex_we,
  input  logic             i_ex_isLoad,
  input  logic [4:0]       i_mem_wa,
  input  logic             i_mem_we,
  input  logic [4:0]       i_wb_wa,
  input  logic             i_wb_we,
  output logic             o_stallF,
  output logic             o_stallD,
  output logic             o_flushE,
  output logic [1:0]       o_fwdA,
  output logic [1:0]       o_fwdB,
  output logic             o_mdu_start,
  output logic             o_mdu_busy,
  output logic [CNT_W-1:0] o_stall_cnt,
  output hz_state_t        o_state
);

  localparam logic [5:0] LAT = 6'(MDU_LAT);

  logic [5:0] mdu_cnt;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       haz_load;
  logic       haz_mdu;
  logic       stall;

  fwd_sel u_fwd_a (
    .src        (i_id_rs),
    .en         (i_id_useRs),
    .ex_wa      (i_ex_wa),
    .ex_we      (i_ex_we),
    .ex_is_load (i_ex_isLoad),
    .mem_wa     (i_mem_wa),
    .mem_we     (i_mem_we),
    .wb_wa      (i_wb_wa),
    .wb_we      (i_wb_we),
    .sel        (sel_a)
  );

  fwd_sel u_fwd_b (
    .src        (i_id_rt),
    .en         (i_id_useRt),
    .ex_wa      (i_ex_wa),
    .ex_we      (i_ex_we),
    .ex_is_load (i_ex_isLoad),
    .mem_wa     (i_mem_wa),
    .mem_we     (i_mem_we),
    .wb_wa      (i_wb_wa),
    .wb_we      (i_wb_we),
    .sel        (sel_b)
  );

  // hazard detection; everything is held quiet while in reset
  always_comb begin
    o_mdu_busy = !rst && (mdu_cnt != 6'd0);
    haz_load   = !rst && i_id_valid && i_ex_isLoad &&
                 ((reg_match(i_id_rs, i_ex_wa, i_ex_we) && i_id_useRs) ||
                  (reg_match(i_id_rt, i_ex_wa, i_ex_we) && i_id_useRt));
    haz_mdu    = !rst && i_id_valid &&
                 (i_id_isMdu || i_id_readsHiLo) && o_mdu_busy;
    stall       = haz_load || haz_mdu;
    o_stallF    = stall;
    o_stallD    = stall;
    o_flushE    = stall;
    o_mdu_start = !rst && i_id_valid && i_id_isMdu && !stall;
    o_fwdA      = rst ? FWD_RF : sel_a;
    o_fwdB      = rst ? FWD_RF : sel_b;
  end

  // stall-cause FSM: load wins when both hazards coincide
  always_ff @(posedge clk) begin
    if (rst) begin
      o_state <= RUN;
    end else if (haz_load) begin
      o_state <= LOAD;
    end else if (haz_mdu) begin
      o_state <= MDUW;
    end else begin
      o_state <= RUN;
    end
  end

  // MDU busy countdown, reloaded on issue
  always_ff @(posedge clk) begin
    if (rst) begin
      mdu_cnt <= 6'd0;
    end else if (o_mdu_start) begin
      mdu_cnt <= LAT;
    end else if (mdu_cnt != 6'd0) begin
      mdu_cnt <= mdu_cnt - 6'd1;
    end
  end

  // saturating stall-cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      o_stall_cnt <= '0;
    end else if (stall && (o_stall_cnt != '1)) begin
      o_stall_cnt <= o_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then
// random traffic against a cycle-count based reference model.
module tb_hazard_ctrl;
  import cpu_pkg::*;

  localparam int LAT  = 4;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_useRs, id_useRt, id_isMdu, id_readsHiLo;
  logic [4:0] id_rs, id_rt, ex_wa, mem_wa, wb_wa;
  logic ex_we, ex_isLoad, mem_we, wb_we;
  logic stallF, stallD, flushE, mdu_start, mdu_busy;
  logic [1:0] fwdA, fwdB;
  logic [CW-1:0] stall_cnt;
  hz_state_t state;

  int checks = 0;
  int failures = 0;

  int unsigned m_cyc = 0;
  int unsigned m_busy_end = 0;
  int m_scnt = 0;
  hz_state_t m_st = RUN;

  always #5 clk = ~clk;

  hazard_ctrl #(.MDU_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_useRs(id_useRs), .i_id_useRt(id_useRt),
    .i_id_isMdu(id_isMdu), .i_id_readsHiLo(id_readsHiLo),
    .i_ex_wa(ex_wa), .i_ex_we(ex_we), .i_ex_isLoad(ex_isLoad),
    .i_mem_wa(mem_wa), .i_mem_we(mem_we),
    .i_wb_wa(wb_wa), .i_wb_we(wb_we),
    .o_stallF(stallF), .o_stallD(stallD), .o_flushE(flushE),
    .o_fwdA(fwdA), .o_fwdB(fwdB),
    .o_mdu_start(mdu_start), .o_mdu_busy(mdu_busy),
    .o_stall_cnt(stall_cnt), .o_state(state)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic wr(input logic [4:0] s, input logic [4:0] w,
                              input logic e);
    return e && w != 5'd0 && s == w;
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [4:0] s,
                                         input logic en);
    if (!en || s == 5'd0) return 2'b00;
    if (wr(s, ex_wa, ex_we)) return ex_isLoad ? 2'b00 : 2'b01;
    if (wr(s, mem_wa, mem_we)) return 2'b10;
    if (wr(s, wb_wa, wb_we)) return 2'b11;
    return 2'b00;
  endfunction

  task automatic idle();
    rst = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_useRs = 0;
    id_useRt = 0; id_isMdu = 0; id_readsHiLo = 0;
    ex_wa = 0; ex_we = 0; ex_isLoad = 0;
    mem_wa = 0; mem_we = 0; wb_wa = 0; wb_we = 0;
  endtask

  // one clock: check comb outputs vs model, advance model, check regs
  task automatic tick();
    logic bs, hl, hm, sv, go;
    logic [1:0] fa, fb;
    #1;
    bs = !rst && (m_cyc < m_busy_end);
    hl = !rst && id_valid && ex_isLoad &&
         ((id_useRs && wr(id_rs, ex_wa, ex_we)) ||
          (id_useRt && wr(id_rt, ex_wa, ex_we)));
    hm = !rst && id_valid && (id_isMdu || id_readsHiLo) && bs;
    sv = hl || hm;
    go = !rst && id_valid && id_isMdu && !sv;
    fa = rst ? 2'b00 : ref_fwd(id_rs, id_useRs);
    fb = rst ? 2'b00 : ref_fwd(id_rt, id_useRt);
    chk("fwdA", 32'(fwdA), 32'(fa));
    chk("fwdB", 32'(fwdB), 32'(fb));
    chk("stallF", 32'(stallF), 32'(sv));
    chk("stallD", 32'(stallD), 32'(sv));
    chk("flushE", 32'(flushE), 32'(sv));
    chk("mdu_start", 32'(mdu_start), 32'(go));
    chk("mdu_busy", 32'(mdu_busy), 32'(bs));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
    @(posedge clk);
    if (rst) begin
      m_busy_end = 0;
      m_scnt = 0;
      m_st = RUN;
    end else begin
      if (go) m_busy_end = m_cyc + 1 + LAT;
      if (sv && m_scnt < CMAX) m_scnt++;
      m_st = hl ? LOAD : (hm ? MDUW : RUN);
    end
    m_cyc++;
    #2;
    chk("state", 32'(state), 32'(m_st));
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk);
    #2;
    // 1: reset held with every hazard driven
    for (int i = 0; i < 3; i++) begin
      rst = 1; id_valid = 1; id_rs = 5; id_rt = 8;
      id_useRs = 1; id_useRt = 1; id_isMdu = 1; id_readsHiLo = 1;
      ex_wa = 8; ex_we = 1; ex_isLoad = 1;
      mem_wa = 5; mem_we = 1; wb_wa = 5; wb_we = 1;
      #1;
      chk("rst_stall", 32'(stallF), 0);
      chk("rst_fwdA", 32'(fwdA), 0);
      chk("rst_start", 32'(mdu_start), 0);
      tick();
      chk("rst_cnt", 32'(stall_cnt), 0);
    end
    // 2: forwarding priority
    idle(); id_valid = 1; id_rs = 5; id_useRs = 1;
    ex_wa = 5; ex_we = 1; #1; chk("t2_ex", 32'(fwdA), 1); tick();
    idle(); id_valid = 1; id_rs = 5; id_useRs = 1;
    mem_wa = 5; mem_we = 1; #1; chk("t2_mem", 32'(fwdA), 2); tick();
    idle(); id_valid = 1; id_rs = 5; id_useRs = 1;
    wb_wa = 5; wb_we = 1; #1; chk("t2_wb", 32'(fwdA), 3); tick();
    ex_wa = 5; ex_we = 1; mem_wa = 5; mem_we = 1;
    #1; chk("t2_all", 32'(fwdA), 1); tick();
    idle(); id_valid = 1; id_useRs = 1; ex_we = 1;
    #1; chk("t2_r0", 32'(fwdA), 0); tick();
    // 3: load-use, one bubble then forwarded from MEM
    do_reset();
    id_valid = 1; id_rt = 8; id_useRt = 1;
    ex_wa = 8; ex_we = 1; ex_isLoad = 1;
    #1; chk("t3_stall", 32'(stallD), 1);
    chk("t3_flush", 32'(flushE), 1); tick();
    idle(); id_valid = 1; id_rt = 8; id_useRt = 1;
    mem_wa = 8; mem_we = 1;
    #1; chk("t3_nostall", 32'(stallD), 0);
    chk("t3_fwdB", 32'(fwdB), 2);
    chk("t3_cnt", 32'(stall_cnt), 1); tick();
    // 4: mult then mflo, then back-to-back mults
    do_reset();
    id_valid = 1; id_isMdu = 1;
    #1; chk("t4_start", 32'(mdu_start), 1); tick();
    idle(); id_valid = 1; id_readsHiLo = 1;
    for (int i = 0; i < LAT; i++) begin
      #1; chk("t4_mflo_stall", 32'(stallF), 1); tick();
    end
    #1; chk("t4_mflo_go", 32'(stallF), 0);
    chk("t4_cnt", 32'(stall_cnt), 4); tick();
    do_reset();
    id_valid = 1; id_isMdu = 1; tick();
    for (int i = 0; i < LAT; i++) begin
      #1; chk("t4_mult2_stall", 32'(stallF), 1); tick();
    end
    #1; chk("t4_mult2_start", 32'(mdu_start), 1); tick();
    // 5: coincident hazards, then saturation
    do_reset();
    id_valid = 1; id_isMdu = 1; tick();
    idle(); id_valid = 1; id_readsHiLo = 1; id_rt = 8; id_useRt = 1;
    ex_wa = 8; ex_we = 1; ex_isLoad = 1; tick();
    chk("t5_state", 32'(state), 32'(LOAD));
    chk("t5_cnt", 32'(stall_cnt), 1);
    idle(); id_valid = 1; id_rs = 3; id_useRs = 1;
    ex_wa = 3; ex_we = 1; ex_isLoad = 1;
    for (int i = 0; i < 20; i++) tick();
    chk("t5_sat", 32'(stall_cnt), 15);
    // 6: reset mid-MDU drops busy
    do_reset();
    id_valid = 1; id_isMdu = 1; tick();
    idle(); tick(); tick();
    rst = 1; tick();
    idle(); id_valid = 1; id_readsHiLo = 1;
    #1; chk("t6_busy", 32'(mdu_busy), 0);
    chk("t6_stall", 32'(stallF), 0);
    chk("t6_state", 32'(state), 32'(RUN)); tick();
    // random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      id_valid = 1'($urandom_range(0, 3) != 0);
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      id_useRs = 1'($urandom_range(0, 1));
      id_useRt = 1'($urandom_range(0, 1));
      id_isMdu = 1'($urandom_range(0, 5) == 0);
      id_readsHiLo = 1'($urandom_range(0, 3) == 0);
      ex_wa = 5'($urandom_range(0, 3));
      ex_we = 1'($urandom_range(0, 1));
      ex_isLoad = 1'($urandom_range(0, 2) == 0);
      mem_wa = 5'($urandom_range(0, 3));
      mem_we = 1'($urandom_range(0, 1));
      wb_wa = 5'($urandom_range(0, 3));
      wb_we = 1'($urandom_range(0, 1));
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
